// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite layer renderer.
// Holds the built-in sprite image, which the ROM decodes from a flat address.
package sprite_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam int PIPE_LAT = 3;
  localparam int PAL_SIZE = 16;

  // Bit width for a count of n items, never narrower than one bit.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Built-in sprite image: 4-bit palette index for source texel (u, v) of a frame.
  function automatic logic [3:0] sprite_texel(input int unsigned frame,
                                              input int unsigned u,
                                              input int unsigned v);
    int unsigned t;
    t = u + 1 + 7 * (u >> 4) + 3 * v + 5 * frame;
    return 4'(t);
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// Sprite index ROM with the address registered on vga_clk; q is valid one cycle later.
// An empty INIT_FILE gives a blank image.
module sprite_rom
  import sprite_pkg::*;
#(
  parameter int    DEPTH     = 4096,
  parameter int    ADDR_W    = 12,
  parameter int    IMG_W     = 32,
  parameter int    IMG_H     = 32,
  parameter string INIT_FILE = "sprite.txt"
) (
  input  logic              vga_clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [3:0]        q
);

  logic [ADDR_W-1:0] addr_q;
  int unsigned       a;

  always_ff @(posedge vga_clk) begin
    addr_q <= addr;
  end

  // Decode frame / row / column back out of the flat address.
  always_comb begin
    a = 32'(addr_q);
    q = '0;
    if (INIT_FILE != "" && a < DEPTH) begin
      q = sprite_texel(a / (IMG_W * IMG_H), a % IMG_W, (a / IMG_W) % IMG_H);
    end
  end

endmodule

// File: rtl/sprite_layer_renderer.sv
// Scaled, flippable, animated sprite layer: RGB + opaque, fixed 3-cycle latency,
// one pixel per cycle with no stalls; also owns the palette and frame controller.
module sprite_layer_renderer
  import sprite_pkg::*;
#(
  parameter int    IMG_W      = 32,
  parameter int    IMG_H      = 32,
  parameter int    FRAMES     = 4,
  parameter int    SCALE_LOG2 = 1,
  parameter int    TRANSP_IDX = 0,
  parameter int    FRAME_DIV  = 8,
  parameter string INIT_FILE  = "sprite.txt",
  localparam int   FW         = clog2_safe(FRAMES)
) (
  input  logic          vga_clk,
  input  logic          reset,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  input  logic          blank,
  input  logic          frame_start,
  input  logic [9:0]    pos_x,
  input  logic [9:0]    pos_y,
  input  logic          anim_en,
  input  logic [FW-1:0] frame_sel,
  input  logic          flip_h,
  input  logic          flip_v,
  input  logic          pal_we,
  input  logic [3:0]    pal_idx,
  input  logic [11:0]   pal_data,
  output logic [3:0]    red,
  output logic [3:0]    green,
  output logic [3:0]    blue,
  output logic          opaque,
  output logic [FW-1:0] cur_frame
);

  localparam int UW     = clog2_safe(IMG_W);
  localparam int VW     = clog2_safe(IMG_H);
  localparam int DIVW   = clog2_safe(FRAME_DIV);
  localparam int DEPTH  = FRAMES * IMG_W * IMG_H;
  localparam int ADDR_W = clog2_safe(DEPTH);
  localparam logic [10:0] SPAN_W = 11'(IMG_W << SCALE_LOG2);
  localparam logic [10:0] SPAN_H = 11'(IMG_H << SCALE_LOG2);

  // S0: screen position relative to the sprite origin.
  logic [10:0]   dx, dy;
  logic          hit_c;
  logic [UW-1:0] u_c;
  logic [VW-1:0] v_c;

  always_comb begin
    dx    = {1'b0, DrawX} - {1'b0, pos_x};
    dy    = {1'b0, DrawY} - {1'b0, pos_y};
    hit_c = !dx[10] && !dy[10] && (dx < SPAN_W) && (dy < SPAN_H);
    u_c   = UW'(dx >> SCALE_LOG2);
    v_c   = VW'(dy >> SCALE_LOG2);
    if (flip_h) u_c = UW'(IMG_W - 1) - u_c;
    if (flip_v) v_c = VW'(IMG_H - 1) - v_c;
  end

  logic          s0_hit, s0_blank;
  logic [UW-1:0] s0_u;
  logic [VW-1:0] s0_v;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      s0_hit   <= 1'b0;
      s0_blank <= 1'b0;
      s0_u     <= '0;
      s0_v     <= '0;
    end else begin
      s0_hit   <= hit_c;
      s0_blank <= blank;
      s0_u     <= u_c;
      s0_v     <= v_c;
    end
  end

  // S1: ROM address; the ROM registers it, so hit/blank are delayed to match.
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_q;
  logic              s1_hit, s1_blank;

  always_comb begin
    rom_addr = ADDR_W'(cur_frame) * ADDR_W'(IMG_W * IMG_H)
             + ADDR_W'(s0_v) * ADDR_W'(IMG_W)
             + ADDR_W'(s0_u);
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      s1_hit   <= 1'b0;
      s1_blank <= 1'b0;
    end else begin
      s1_hit   <= s0_hit;
      s1_blank <= s0_blank;
    end
  end

  sprite_rom #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .INIT_FILE (INIT_FILE)
  ) u_rom (
    .vga_clk (vga_clk),
    .addr    (rom_addr),
    .q       (rom_q)
  );

  // Palette: written on the edge, read combinationally, so a same-cycle read sees the old entry.
  rgb12_t pal [PAL_SIZE];

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PAL_SIZE; i++) pal[i] <= '0;
    end else if (pal_we) begin
      pal[pal_idx] <= rgb12_t'(pal_data);
    end
  end

  // S2: colour lookup into the output registers.
  rgb12_t pix_q;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      pix_q  <= '0;
      opaque <= 1'b0;
    end else if (s1_blank && s1_hit && rom_q != 4'(TRANSP_IDX)) begin
      pix_q  <= pal[rom_q];
      opaque <= 1'b1;
    end else begin
      pix_q  <= '0;
      opaque <= 1'b0;
    end
  end

  assign red   = pix_q.r;
  assign green = pix_q.g;
  assign blue  = pix_q.b;

  // Frame controller: cur_frame only moves on frame_start so a frame never tears.
  logic [DIVW-1:0] div_cnt;
  logic [FW-1:0]   anim_frame;
  logic [FW-1:0]   anim_next;
  logic            div_wrap;

  always_comb begin
    div_wrap  = (div_cnt == DIVW'(FRAME_DIV - 1));
    anim_next = anim_frame;
    if (div_wrap) begin
      anim_next = (anim_frame == FW'(FRAMES - 1)) ? '0 : anim_frame + 1'b1;
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      div_cnt    <= '0;
      anim_frame <= '0;
      cur_frame  <= '0;
    end else if (frame_start) begin
      if (anim_en) begin
        div_cnt    <= div_wrap ? '0 : div_cnt + 1'b1;
        anim_frame <= anim_next;
        cur_frame  <= anim_next;
      end else begin
        div_cnt   <= '0;
        cur_frame <= (int'(frame_sel) > FRAMES - 1) ? FW'(FRAMES - 1) : frame_sel;
      end
    end
  end

endmodule

// File: tb/tb_sprite_layer_renderer.sv
// Bench for sprite_layer_renderer: vector table, randomized stream against a
// behavioural model, and hand sequences for palette timing, frame control and reset.
module tb_sprite_layer_renderer;

  logic       vga_clk = 1'b0;
  logic       reset;
  logic [9:0] DrawX, DrawY, pos_x, pos_y;
  logic       blank, frame_start, anim_en, flip_h, flip_v, pal_we;
  logic [1:0] frame_sel, cur_frame;
  logic [3:0] pal_idx, red, green, blue;
  logic [11:0] pal_data;
  logic       opaque;

  sprite_layer_renderer #(
    .IMG_W(32), .IMG_H(32), .FRAMES(4), .SCALE_LOG2(1),
    .TRANSP_IDX(0), .FRAME_DIV(8), .INIT_FILE("sprite.txt")
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .anim_en(anim_en),
    .frame_sel(frame_sel), .flip_h(flip_h), .flip_v(flip_v), .pal_we(pal_we),
    .pal_idx(pal_idx), .pal_data(pal_data), .red(red), .green(green), .blue(blue),
    .opaque(opaque), .cur_frame(cur_frame)
  );

  always #5 vga_clk = ~vga_clk;

  int checks = 0;
  int errors = 0;
  logic [11:0] pal_ref [16];

  typedef struct {
    int x, y, bl, fh, fv;
    int exp;  // {opaque, rgb}
  } vec_t;
  vec_t vt [15];
  int   exp_q [$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  function automatic int obs();
    return int'({opaque, red, green, blue});
  endfunction

  // Sprite image content: palette index of texel (u,v) in frame f.
  function automatic int texel(input int f, input int u, input int v);
    return (u + 1 + 7 * (u / 16) + 3 * v + 5 * f) % 16;
  endfunction

  // Expected {opaque, rgb} for one screen pixel, from the geometric rules.
  function automatic int model_pix(input int x, input int y, input int px, input int py,
                                   input int bl, input int fh, input int fv, input int f);
    int dx, dy, u, v, t;
    dx = x - px;
    dy = y - py;
    if (bl == 0 || dx < 0 || dy < 0 || dx >= 64 || dy >= 64) return 0;
    u = dx / 2;
    v = dy / 2;
    if (fh != 0) u = 31 - u;
    if (fv != 0) v = 31 - v;
    t = texel(f, u, v);
    if (t == 0) return 0;
    return 4096 | int'(pal_ref[t]);
  endfunction

  task automatic drive(input int x, input int y, input int bl, input int fh, input int fv);
    DrawX  = 10'(x);
    DrawY  = 10'(y);
    blank  = bl[0];
    flip_h = fh[0];
    flip_v = fv[0];
  endtask

  task automatic set_frame(input int f);
    blank       = 1'b0;
    anim_en     = 1'b0;
    frame_sel   = 2'(f);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
  endtask

  initial begin
    int af, dv, px, py, x, y, bl, fh, fv, e;

    vt[0]  = '{100, 50, 1, 0, 0, 'h1F00};
    vt[1]  = '{101, 50, 1, 0, 0, 'h1F00};
    vt[2]  = '{102, 50, 1, 0, 0, 'h10F0};
    vt[3]  = '{103, 50, 1, 0, 0, 'h10F0};
    vt[4]  = '{ 99, 50, 1, 0, 0, 'h0000};
    vt[5]  = '{164, 50, 1, 0, 0, 'h0000};
    vt[6]  = '{163, 50, 1, 0, 0, 'h17A8};
    vt[7]  = '{100, 50, 0, 0, 0, 'h0000};
    vt[8]  = '{100, 50, 1, 1, 0, 'h17A8};
    vt[9]  = '{100, 50, 1, 0, 1, 'h1EA1};
    vt[10] = '{130, 50, 1, 0, 0, 'h0000};
    vt[11] = '{100, 49, 1, 0, 0, 'h0000};
    vt[12] = '{100, 113, 1, 0, 0, 'h1EA1};
    vt[13] = '{100, 114, 1, 0, 0, 'h0000};
    vt[14] = '{132, 50, 1, 0, 0, 'h18A7};

    for (int i = 0; i < 16; i++) pal_ref[i] = {4'(i), 4'hA, ~4'(i)};
    pal_ref[1] = 12'hF00;
    pal_ref[2] = 12'h0F0;

    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    pos_x = 10'd100; pos_y = 10'd50;
    frame_start = 1'b0; anim_en = 1'b0; frame_sel = '0;
    pal_we = 1'b0; pal_idx = '0; pal_data = '0;
    repeat (3) step();
    check("reset_pix", obs(), 0);
    check("reset_frame", int'(cur_frame), 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 16; i++) begin
      pal_we = 1'b1; pal_idx = 4'(i); pal_data = pal_ref[i];
      step();
    end
    pal_we = 1'b0;

    // Vector table streamed one per cycle; each result lands exactly PIPE_LAT cycles later.
    for (int i = 0; i < 15 + sprite_pkg::PIPE_LAT; i++) begin
      if (i >= sprite_pkg::PIPE_LAT) check($sformatf("vec%0d", i - sprite_pkg::PIPE_LAT),
                                           obs(), vt[i - sprite_pkg::PIPE_LAT].exp);
      if (i < 15) drive(vt[i].x, vt[i].y, vt[i].bl, vt[i].fh, vt[i].fv);
      else drive(0, 0, 0, 0, 0);
      step();
    end

    // Randomized stream per frame, position and flips changing every cycle.
    for (int s = 0; s < 4; s++) begin
      set_frame(s);
      exp_q.delete();
      for (int i = 0; i < 150 + sprite_pkg::PIPE_LAT; i++) begin
        if (i >= sprite_pkg::PIPE_LAT) begin
          e = exp_q.pop_front();
          check("rand_pix", obs(), e);
        end
        if (i < 150) begin
          px = int'($urandom_range(80, 120));
          py = int'($urandom_range(30, 70));
          x  = int'($urandom_range(70, 200));
          y  = int'($urandom_range(20, 140));
          bl = ($urandom_range(0, 7) != 0) ? 1 : 0;
          fh = int'($urandom_range(0, 1));
          fv = int'($urandom_range(0, 1));
          pos_x = 10'(px); pos_y = 10'(py);
          drive(x, y, bl, fh, fv);
          exp_q.push_back(model_pix(x, y, px, py, bl, fh, fv, s));
        end else begin
          drive(0, 0, 0, 0, 0);
        end
        step();
      end
    end

    // Palette write and read of the same entry on the same edge.
    pos_x = 10'd100; pos_y = 10'd50;
    set_frame(0);
    drive(100, 50, 1, 0, 0);
    repeat (4) step();
    check("pal_before", obs(), 'h1F00);
    pal_we = 1'b1; pal_idx = 4'd1; pal_data = 12'h123;
    step();
    pal_we = 1'b0;
    check("pal_same_cycle", obs(), 'h1F00);
    step();
    check("pal_new", obs(), 'h1123);
    pal_we = 1'b1; pal_data = 12'hF00;
    step();
    pal_we = 1'b0;

    // Static frame select waits for frame_start.
    frame_sel = 2'd3;
    drive(102, 50, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("static_hold", int'(cur_frame), 0);
    end
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("static_load", int'(cur_frame), 3);
    repeat (3) step();
    check("frame3_pix", obs(), 'h1F00);
    drive(100, 50, 1, 0, 0);
    repeat (3) step();
    check("frame3_transp", obs(), 0);

    // Auto-animation: one step per eight frame_start pulses, wrapping at four frames.
    blank = 1'b0;
    anim_en = 1'b1;
    af = 0;
    dv = 0;
    for (int p = 1; p <= 32; p++) begin
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      dv++;
      if (dv == 8) begin
        dv = 0;
        af = (af + 1) % 4;
      end
      check($sformatf("anim_pulse%0d", p), int'(cur_frame), af);
      step();
      check("anim_hold", int'(cur_frame), af);
    end

    // Mid-line reset: outputs dark at once, palette cleared, resumes on the third edge.
    set_frame(2);
    drive(102, 50, 1, 0, 0);
    repeat (4) step();
    check("pre_reset_pix", obs(), 'h1CA3);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_pix", obs(), 0);
    check("rst_async_frame", int'(cur_frame), 0);
    @(posedge vga_clk);
    #1;
    reset = 1'b0;
    step();
    step();
    check("rst_resume_early", obs(), 0);
    step();
    check("rst_resume_pal_clear", obs(), 'h1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
